// File: rtl/sync_frame_tx_1101.sv
// Serial frame transmitter: 1101 sync header, MSB-first payload, optional even
// parity bit, then a programmable run of idle zeros before the next word.
//
// state  | meaning
// IDLE   | waiting for din_valid; din_ready high
// SYNC   | sending the 1101 header
// DATA   | shifting the payload out MSB first
// PAR    | sending the even-parity bit
// GAP    | idle zeros before returning to IDLE

module sync_frame_tx_1101 #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int GW      = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] SYNC_LOAD = CW'(3);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [3:0]    SYNC_PAT  = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  localparam state_t AFTER_PAR  = (GAP > 0) ? S_GAP : S_IDLE;
  localparam state_t AFTER_DATA = (PARITY_EN != 0) ? S_PAR : AFTER_PAR;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [GW-1:0]     gcnt, gcnt_nxt;
  logic [DATA_W-1:0] sreg;
  logic              par;
  logic              tx_bit_d, tx_en_d, busy_d, done_d;
  logic              in_frame;

  // Outputs are registered copies of what the next state will drive, so
  // they line up with the state register rather than lagging it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      sreg   <= '0;
      par    <= 1'b0;
      tx_bit <= 1'b0;
      tx_en  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      gcnt   <= gcnt_nxt;
      tx_bit <= tx_bit_d;
      tx_en  <= tx_en_d;
      busy   <= busy_d;
      done   <= done_d;
      if (state == S_IDLE && din_valid) begin
        sreg <= din;
        par  <= ^din;
      end else if (state_nxt == S_DATA) begin
        sreg <= sreg << 1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    case (state)
      S_IDLE: begin
        if (din_valid) begin
          state_nxt = S_SYNC;
          cnt_nxt   = SYNC_LOAD;
        end
      end
      S_SYNC: begin
        if (cnt == '0) begin
          state_nxt = S_DATA;
          cnt_nxt   = DATA_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          state_nxt = AFTER_DATA;
          gcnt_nxt  = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_PAR: begin
        state_nxt = AFTER_PAR;
        gcnt_nxt  = GAP_LOAD;
      end
      S_GAP: begin
        if (gcnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          gcnt_nxt = gcnt - GW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit_d = 1'b0;
    tx_en_d  = 1'b0;
    case (state_nxt)
      S_SYNC: begin
        tx_bit_d = SYNC_PAT[cnt_nxt[1:0]];
        tx_en_d  = 1'b1;
      end
      S_DATA: begin
        tx_bit_d = sreg[DATA_W-1];
        tx_en_d  = 1'b1;
      end
      S_PAR: begin
        tx_bit_d = par;
        tx_en_d  = 1'b1;
      end
      default: ;
    endcase
    in_frame = (state == S_SYNC) || (state == S_DATA) || (state == S_PAR);
    busy_d   = (state_nxt != S_IDLE);
    done_d   = in_frame && !tx_en_d;
  end

  assign din_ready = (state == S_IDLE);

endmodule
